// File: rtl/conv_psum_acc.sv
// Partial-sum accumulator behind the CONV systolic array: sums COLUMN-wide beats across tiles.
// Define PSUM_ACC_SAT_EN for saturating adds; the default build wraps modulo 2^AW.
module conv_psum_acc #(
  parameter int COLUMN = 7,
  parameter int IW     = 26,
  parameter int AW     = 32,
  parameter int DEPTH  = 64,
  parameter int TW     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
  input  logic [TW-1:0]                cfg_tiles,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [COLUMN*IW-1:0]         s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [COLUMN*AW-1:0]         m_data,
  output logic                         busy,
  output logic                         done
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;

  state_t               r_state, w_next;
  logic [LW-1:0]        r_len, r_pos;
  logic [TW-1:0]        r_tiles, r_tile;
  logic [COLUMN*AW-1:0] r_buf [DEPTH];
  logic [COLUMN*AW-1:0] r_m_data;
  logic                 r_m_valid, r_busy, r_done;

  logic                 w_s_ready, w_s_fire, w_m_fire, w_start_acc;
  logic                 w_final_tile, w_last_pos, w_last_beat, w_buf_we;
  logic [COLUMN*AW-1:0] w_ext, w_sum;

  function automatic logic [AW-1:0] f_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] s;
    s = a + b;
`ifdef PSUM_ACC_SAT_EN
    if ((a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1]))
      s = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`endif
    return s;
  endfunction

  assign w_final_tile = (r_tile == r_tiles - TW'(1));
  assign w_last_pos   = (r_pos == r_len - LW'(1));

  // State register, counters and latched configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_tiles <= '0;
      r_pos   <= '0;
      r_tile  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DRAIN) && w_m_fire;
      if (w_start_acc)  r_busy <= 1'b1;
      else if (r_done)  r_busy <= 1'b0;
      if (w_start_acc) begin
        r_len   <= (cfg_len == '0) ? LW'(1) : cfg_len;
        r_tiles <= (cfg_tiles == '0) ? TW'(1) : cfg_tiles;
        r_pos   <= '0;
        r_tile  <= '0;
      end else if (w_s_fire) begin
        if (w_last_pos) begin
          r_pos  <= '0;
          r_tile <= r_tile + TW'(1);
        end else begin
          r_pos  <= r_pos + LW'(1);
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)       w_next = S_ACC;
      S_ACC:   if (w_last_beat) w_next = S_DRAIN;
      S_DRAIN: if (w_m_fire)    w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // The final tile may only advance when the output register is free or draining this cycle
  always_comb begin
    w_start_acc = start && (r_state == S_IDLE);
    w_s_ready   = (r_state == S_ACC) && (!w_final_tile || !r_m_valid || m_ready);
    w_s_fire    = s_valid && w_s_ready;
    w_m_fire    = r_m_valid && m_ready;
    w_last_beat = w_s_fire && w_final_tile && w_last_pos;
    w_buf_we    = w_s_fire && !w_final_tile;
  end

  always_comb begin
    w_ext = '0;
    w_sum = '0;
    for (int unsigned c = 0; c < COLUMN; c++) begin
      w_ext[c*AW +: AW] = AW'(signed'(s_data[c*IW +: IW]));
      if (r_tile == '0)
        w_sum[c*AW +: AW] = w_ext[c*AW +: AW];
      else
        w_sum[c*AW +: AW] = f_add(r_buf[r_pos[PW-1:0]][c*AW +: AW], w_ext[c*AW +: AW]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_buf_we)
      r_buf[r_pos[PW-1:0]] <= w_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_s_fire && w_final_tile) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_sum;
    end else if (w_m_fire) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
